// File: rtl/trig_effi_scan_ctrl.sv
// trig_effi_scan_ctrl
// -------------------
// Scan scheduler for the trigger-efficiency test block. It steps a
// discriminator threshold DAC code from DacStart to DacEnd in DacStep
// increments. For every point it:
//   - requests a slow-control reload;
//   - waits SETTLE_CYCLES for the analog front end;
//   - runs one measurement and forwards the test block data words to the
//     readout FIFO;
//   - releases the test block.
//
// Optional feature macro: SCAN_TAG_EN
//   defined   : each point is preceded by a tag word
//               {4'hD, 2'b00, code[9:0]}, and the scan ends with a
//               16'hE0E0 trailer word.
//   undefined : ScanData carries test block words only.
//
// Parameters
//   DAC_WIDTH     threshold DAC code width (max 15)
//   SETTLE_CYCLES Clk cycles between ScLoadDone and the measurement (>= 1)
//
// Ports
//   Clk, reset_n            clock, asynchronous active-low reset
//   ScanStart, ScanStop     start level (rising edge acts), one-cycle abort
//   DacStart/DacEnd/DacStep scan range, sampled on scan start
//   DacCode, ScLoadReq      code to slow control, one-cycle reload request
//   ScLoadDone              reload complete pulse
//   TestStart, TestReset_n  test block start level and active-low reset
//   TestDone                test block finished (level)
//   TestDataTransmitDone    one-cycle release pulse to the test block
//   TestData, TestData_en   test block data word stream
//   ScanData, ScanData_en   word stream to the readout FIFO
//   FifoFull                readout FIFO full; words offered while full are dropped
//   ScanBusy, ScanDone      status
//   Overflow                sticky word-drop flag, cleared on scan start
module trig_effi_scan_ctrl #(
  parameter int DAC_WIDTH     = 10,
  parameter int SETTLE_CYCLES = 4000
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 ScanStart,
  input  logic                 ScanStop,
  input  logic [DAC_WIDTH-1:0] DacStart,
  input  logic [DAC_WIDTH-1:0] DacEnd,
  input  logic [DAC_WIDTH-1:0] DacStep,
  output logic [DAC_WIDTH-1:0] DacCode,
  output logic                 ScLoadReq,
  input  logic                 ScLoadDone,
  output logic                 TestStart,
  output logic                 TestReset_n,
  input  logic                 TestDone,
  output logic                 TestDataTransmitDone,
  input  logic [15:0]          TestData,
  input  logic                 TestData_en,
  output logic [15:0]          ScanData,
  output logic                 ScanData_en,
  input  logic                 FifoFull,
  output logic                 ScanBusy,
  output logic                 ScanDone,
  output logic                 Overflow
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_SC,
    S_WAIT_SC,
    S_SETTLE,
    S_TAG,
    S_RUN,
    S_WAIT_DONE,
    S_ACK,
    S_NEXT,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [DAC_WIDTH-1:0] dac_code_reg, dac_code_next;
  logic [DAC_WIDTH-1:0] dac_end_reg, dac_end_next;
  logic [DAC_WIDTH-1:0] dac_step_reg, dac_step_next;
  logic [CNT_W-1:0]     settle_cnt_reg, settle_cnt_next;
  logic                 test_start_reg, test_start_next;
  logic                 test_reset_n_reg, test_reset_n_next;
  logic [15:0]          scan_data_reg, scan_data_next;
  logic                 scan_data_en_reg, scan_data_en_next;
  logic                 overflow_reg, overflow_next;
  logic                 scan_start_d_reg;

  logic                 start_edge;
  logic                 stop_hit;
  logic [DAC_WIDTH:0]   dac_sum;
  logic                 emit_req;
  logic [15:0]          emit_word;

  assign start_edge = ScanStart & ~scan_start_d_reg;
  assign stop_hit   = ScanStop && (state_reg != S_IDLE) && (state_reg != S_DONE);
  // One extra bit so a step past the top code shows up as a carry instead
  // of wrapping back to a low code.
  assign dac_sum    = {1'b0, dac_code_reg} + {1'b0, dac_step_reg};

`ifdef SCAN_TAG_EN
  logic [9:0] tag_code;
  if (DAC_WIDTH >= 10) begin : g_tag_trunc
    assign tag_code = dac_code_reg[9:0];
  end else begin : g_tag_ext
    assign tag_code = {{(10 - DAC_WIDTH){1'b0}}, dac_code_reg};
  end
`endif

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      dac_code_reg     <= '0;
      dac_end_reg      <= '0;
      dac_step_reg     <= '0;
      settle_cnt_reg   <= '0;
      test_start_reg   <= 1'b0;
      test_reset_n_reg <= 1'b0;
      scan_data_reg    <= '0;
      scan_data_en_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      scan_start_d_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      dac_code_reg     <= dac_code_next;
      dac_end_reg      <= dac_end_next;
      dac_step_reg     <= dac_step_next;
      settle_cnt_reg   <= settle_cnt_next;
      test_start_reg   <= test_start_next;
      test_reset_n_reg <= test_reset_n_next;
      scan_data_reg    <= scan_data_next;
      scan_data_en_reg <= scan_data_en_next;
      overflow_reg     <= overflow_next;
      scan_start_d_reg <= ScanStart;
    end
  end

  always_comb begin
    state_next        = state_reg;
    dac_code_next     = dac_code_reg;
    dac_end_next      = dac_end_reg;
    dac_step_next     = dac_step_reg;
    settle_cnt_next   = settle_cnt_reg;
    test_start_next   = test_start_reg;
    test_reset_n_next = test_reset_n_reg;
    scan_data_next    = scan_data_reg;
    scan_data_en_next = 1'b0;
    overflow_next     = overflow_reg;
    emit_req          = 1'b0;
    emit_word         = '0;

    case (state_reg)
      S_IDLE: begin
        test_reset_n_next = 1'b0;
        test_start_next   = 1'b0;
        if (start_edge) begin
          dac_code_next = DacStart;
          dac_end_next  = DacEnd;
          dac_step_next = (DacStep == '0) ? DAC_WIDTH'(1) : DacStep;
          overflow_next = 1'b0;
          state_next    = S_LOAD_SC;
        end
      end
      S_LOAD_SC: begin
        test_reset_n_next = 1'b1;
        state_next        = S_WAIT_SC;
      end
      S_WAIT_SC: begin
        if (ScLoadDone) begin
          settle_cnt_next = SETTLE_LOAD;
          state_next      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_reg == '0) begin
`ifdef SCAN_TAG_EN
          state_next = S_TAG;
`else
          state_next = S_RUN;
`endif
        end else begin
          settle_cnt_next = settle_cnt_reg - 1'b1;
        end
      end
`ifdef SCAN_TAG_EN
      S_TAG: begin
        emit_req   = 1'b1;
        emit_word  = {4'hD, 2'b00, tag_code};
        state_next = S_RUN;
      end
      S_TRAILER: begin
        emit_req   = 1'b1;
        emit_word  = 16'hE0E0;
        state_next = S_DONE;
      end
`endif
      S_RUN: begin
        test_start_next = 1'b1;
        state_next      = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (TestData_en) begin
          emit_req  = 1'b1;
          emit_word = TestData;
        end
        if (TestDone) begin
          test_start_next = 1'b0;
          state_next      = S_ACK;
        end
      end
      S_ACK: begin
        // TestStart is already low here, so the release pulse sends the
        // test block back to idle instead of starting another run.
        state_next = S_NEXT;
      end
      S_NEXT: begin
        if (dac_sum > {1'b0, dac_end_reg}) begin
`ifdef SCAN_TAG_EN
          state_next = S_TRAILER;
`else
          state_next = S_DONE;
`endif
        end else begin
          dac_code_next = dac_sum[DAC_WIDTH-1:0];
          state_next    = S_LOAD_SC;
        end
      end
      S_DONE: begin
        // Keeps the test block out of reset while the host holds ScanStart;
        // after an abort this ends the one-cycle reset pulse.
        test_reset_n_next = ScanStart;
        if (!ScanStart) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort wins over everything else in the same cycle, including TestDone
    // and any word that would have been forwarded.
    if (stop_hit) begin
      state_next        = S_DONE;
      test_start_next   = 1'b0;
      test_reset_n_next = 1'b0;
      emit_req          = 1'b0;
    end

    // The scan never stalls on a full FIFO: the word is lost and flagged.
    if (emit_req) begin
      if (FifoFull) begin
        overflow_next = 1'b1;
      end else begin
        scan_data_next    = emit_word;
        scan_data_en_next = 1'b1;
      end
    end
  end

  assign DacCode              = dac_code_reg;
  assign ScLoadReq            = (state_reg == S_LOAD_SC);
  assign TestStart            = test_start_reg;
  assign TestReset_n          = test_reset_n_reg;
  assign TestDataTransmitDone = (state_reg == S_ACK);
  assign ScanData             = scan_data_reg;
  assign ScanData_en          = scan_data_en_reg;
  assign ScanBusy             = (state_reg != S_IDLE);
  assign ScanDone             = (state_reg == S_DONE);
  assign Overflow             = overflow_reg;

endmodule

// File: tb/tb_trig_effi_scan_ctrl.sv
// Testbench for trig_effi_scan_ctrl: slow-control and test block models,
// a negedge monitor, and a queue-based reference of the expected scan output.
module tb_trig_effi_scan_ctrl;
  localparam int DW = 10;
  localparam int SC = 4;
`ifdef SCAN_TAG_EN
  localparam int TAGW = 1;
`else
  localparam int TAGW = 0;
`endif

  logic          Clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ScanStart = 1'b0;
  logic          ScanStop = 1'b0;
  logic [DW-1:0] DacStart = '0;
  logic [DW-1:0] DacEnd = '0;
  logic [DW-1:0] DacStep = '0;
  logic [DW-1:0] DacCode;
  logic          ScLoadReq;
  logic          ScLoadDone = 1'b0;
  logic          TestStart;
  logic          TestReset_n;
  logic          TestDone = 1'b0;
  logic          TestDataTransmitDone;
  logic [15:0]   TestData = '0;
  logic          TestData_en = 1'b0;
  logic [15:0]   ScanData;
  logic          ScanData_en;
  logic          FifoFull = 1'b0;
  logic          ScanBusy;
  logic          ScanDone;
  logic          Overflow;

  always #5 Clk = ~Clk;

  trig_effi_scan_ctrl #(.DAC_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
    .Clk(Clk), .reset_n(reset_n), .ScanStart(ScanStart), .ScanStop(ScanStop),
    .DacStart(DacStart), .DacEnd(DacEnd), .DacStep(DacStep), .DacCode(DacCode),
    .ScLoadReq(ScLoadReq), .ScLoadDone(ScLoadDone), .TestStart(TestStart),
    .TestReset_n(TestReset_n), .TestDone(TestDone),
    .TestDataTransmitDone(TestDataTransmitDone), .TestData(TestData),
    .TestData_en(TestData_en), .ScanData(ScanData), .ScanData_en(ScanData_en),
    .FifoFull(FifoFull), .ScanBusy(ScanBusy), .ScanDone(ScanDone), .Overflow(Overflow)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] data_word(input int c, input int i);
    return 16'(32'h1000 + c * 8 + i);
  endfunction

  // Reference: list of scan points and the word stream the FIFO should see.
  task automatic ref_scan(input int s, input int e, input int st, input int n,
                          output int codes[$], output logic [15:0] words[$]);
    int step;
    int c;
    codes = {};
    words = {};
    step = (st == 0) ? 1 : st;
    c = s;
    forever begin
      codes.push_back(c);
      if (TAGW == 1) words.push_back(16'(32'hD000 + c));
      for (int i = 0; i < n; i++) words.push_back(data_word(c, i));
      if (c + step > e || c + step > 1023) break;
      c = c + step;
    end
    if (TAGW == 1) words.push_back(16'hE0E0);
  endtask

  // Monitor plus slow-control loader model (one process, explicit ordering).
  logic [15:0] mon_words[$];
  int          mon_codes[$];
  int          mon_lat[$];
  int          mon_tdt = 0;
  int          cyc_n = 0;
  int          sc_cnt = 0;
  int          sc_done_cyc = 0;
  logic        ts_prev = 1'b0;

  always @(negedge Clk) begin
    cyc_n++;
    if (ScanData_en) mon_words.push_back(ScanData);
    if (ScLoadReq) mon_codes.push_back(int'(DacCode));
    if (TestDataTransmitDone) mon_tdt++;
    if (TestStart && !ts_prev) mon_lat.push_back(cyc_n - sc_done_cyc);
    ts_prev = TestStart;
    ScLoadDone = 1'b0;
    if (!reset_n) begin
      sc_cnt = 0;
    end else if (sc_cnt > 0) begin
      sc_cnt--;
      if (sc_cnt == 0) begin
        ScLoadDone = 1'b1;
        sc_done_cyc = cyc_n;
      end
    end else if (ScLoadReq) begin
      sc_cnt = int'($urandom_range(1, 3));
    end
  end

  // Test block model: words every other cycle, TestDone held until release.
  int   tm_nwords = 6;
  logic stop_arm = 1'b0;
  logic full_arm = 1'b0;
  int   stop_count = 0;
  int   tm_phase = 0;
  int   tm_idx = 0;
  int   tm_gap = 0;
  int   tm_pt = 0;
  int   tm_code = 0;
  int   full_hold = 0;

  always @(negedge Clk) begin
    ScanStop = 1'b0;
    TestData_en = 1'b0;
    if (full_hold > 0) begin
      FifoFull = 1'b1;
      full_hold--;
    end else begin
      FifoFull = 1'b0;
    end
    if (!ScanBusy) tm_pt = 0;
    if (!reset_n || !TestReset_n) begin
      tm_phase = 0;
      TestDone = 1'b0;
    end else begin
      case (tm_phase)
        0: if (TestStart) begin
          tm_code = int'(DacCode);
          tm_idx = 0;
          tm_gap = 2;
          tm_pt++;
          tm_phase = 1;
        end
        1: if (tm_gap > 0) begin
          tm_gap--;
        end else begin
          TestData = data_word(tm_code, tm_idx);
          TestData_en = 1'b1;
          if (full_arm && tm_pt == 1 && tm_idx == 1) begin
            FifoFull = 1'b1;
            full_hold = 1;
          end
          tm_idx++;
          tm_gap = 1;
          if (tm_idx == tm_nwords) tm_phase = 2;
        end
        2: begin
          TestDone = 1'b1;
          if (stop_arm && tm_pt == 1) begin
            ScanStop = 1'b1;
            stop_count++;
          end
          tm_phase = 3;
        end
        3: if (TestDataTransmitDone) begin
          TestDone = 1'b0;
          tm_phase = 0;
        end
        default: tm_phase = 0;
      endcase
    end
  end

  task automatic start_scan(input int s, input int e, input int st);
    @(negedge Clk);
    DacStart = DW'(s);
    DacEnd = DW'(e);
    DacStep = DW'(st);
    ScanStart = 1'b1;
  endtask

  task automatic finish_scan(input string name, input int exp_ovf);
    @(negedge Clk);
    ScanStart = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check({name, "_idle_busy"}, int'(ScanBusy), 0);
    check({name, "_idle_done"}, int'(ScanDone), 0);
    check({name, "_idle_ovf"}, int'(Overflow), exp_ovf);
  endtask

  // Full scan with comparison of points, pulses, latency and word stream.
  task automatic run_scan(input string name, input int s, input int e, input int st,
                          input int n, input int exp_pts, input int drop, input int exp_ovf);
    int codes[$];
    logic [15:0] words[$];
    int wb, cb, lb, tb0, cyc, got_n, lim, exp_n;
    tm_nwords = n;
    ref_scan(s, e, st, n, codes, words);
    if (drop >= 0) words.delete(drop);
    exp_n = (exp_pts >= 0) ? exp_pts : codes.size();
    wb = mon_words.size();
    cb = mon_codes.size();
    lb = mon_lat.size();
    tb0 = mon_tdt;
    start_scan(s, e, st);
    @(posedge Clk);
    #1;
    check({name, "_loadreq_lat"}, int'(ScLoadReq), 1);
    check({name, "_ovf_cleared"}, int'(Overflow), 0);
    cyc = 0;
    while (!ScanDone && cyc < 20000) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    check({name, "_done"}, int'(ScanDone), 1);
    repeat (2) @(posedge Clk);
    #1;
    check({name, "_points"}, mon_codes.size() - cb, exp_n);
    check({name, "_release_pulses"}, mon_tdt - tb0, codes.size());
    if (mon_lat.size() > lb) check({name, "_settle_lat"}, mon_lat[lb], SC + 2 + TAGW);
    else check({name, "_settle_lat"}, -1, SC + 2 + TAGW);
    got_n = mon_codes.size() - cb;
    lim = (got_n < codes.size()) ? got_n : codes.size();
    for (int i = 0; i < lim; i++)
      check($sformatf("%s_code%0d", name, i), mon_codes[cb + i], codes[i]);
    got_n = mon_words.size() - wb;
    check({name, "_word_count"}, got_n, words.size());
    lim = (got_n < words.size()) ? got_n : words.size();
    for (int i = 0; i < lim; i++)
      check($sformatf("%s_word%0d", name, i), int'(mon_words[wb + i]), int'(words[i]));
    check({name, "_ovf"}, int'(Overflow), exp_ovf);
    finish_scan(name, exp_ovf);
  endtask

  typedef struct {
    int s;
    int e;
    int st;
    int n;
    int exp_pts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s, e, st, n, cyc, snap, wb, tb0;

    vecs[0] = '{100, 102, 1, 6, 3};
    vecs[1] = '{10, 5, 1, 2, 1};
    vecs[2] = '{1022, 1023, 0, 2, 2};
    vecs[3] = '{7, 7, 3, 1, 1};
    vecs[4] = '{0, 20, 7, 3, 3};
    vecs[5] = '{1000, 1023, 10, 1, 3};

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_busy", int'(ScanBusy), 0);
    check("rst_dac", int'(DacCode), 0);
    check("rst_test_reset_n", int'(TestReset_n), 0);
    check("rst_scandata", int'(ScanData), 0);
    check("rst_ovf", int'(Overflow), 0);
    check("rst_loadreq", int'(ScLoadReq), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Table-driven scans
    for (int v = 0; v < 6; v++)
      run_scan($sformatf("vec%0d", v), vecs[v].s, vecs[v].e, vecs[v].st, vecs[v].n,
               vecs[v].exp_pts, -1, 0);

    // FIFO full during the second data word of the first point
    full_arm = 1'b1;
    run_scan("fifo_full", 100, 102, 1, 6, 3, TAGW + 1, 1);
    full_arm = 1'b0;
    run_scan("after_full", 50, 51, 1, 2, 2, -1, 0);

    // Abort coinciding with TestDone
    tm_nwords = 6;
    stop_arm = 1'b1;
    wb = mon_words.size();
    tb0 = mon_tdt;
    snap = stop_count;
    start_scan(100, 102, 1);
    cyc = 0;
    while (stop_count == snap && cyc < 2000) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    check("stop_fired", stop_count - snap, 1);
    check("stop_test_reset_n_low", int'(TestReset_n), 0);
    check("stop_teststart", int'(TestStart), 0);
    check("stop_done", int'(ScanDone), 1);
    @(posedge Clk);
    #1;
    check("stop_test_reset_n_back", int'(TestReset_n), 1);
    repeat (10) @(posedge Clk);
    #1;
    stop_arm = 1'b0;
    check("stop_no_release", mon_tdt - tb0, 0);
    check("stop_word_count", mon_words.size() - wb, TAGW + 6);
    if (mon_words.size() > wb)
      check("stop_last_word", int'(mon_words[mon_words.size() - 1]), int'(data_word(100, 5)));
    check("stop_still_done", int'(ScanDone), 1);
    finish_scan("stop", 0);

    // Asynchronous reset in the middle of SETTLE
    tm_nwords = 2;
    start_scan(200, 203, 1);
    cyc = 0;
    while (!ScLoadDone && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    check("mid_settle_reached", int'(ScLoadDone), 1);
    @(posedge Clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", int'(ScanBusy), 0);
    check("arst_dac", int'(DacCode), 0);
    check("arst_test_reset_n", int'(TestReset_n), 0);
    check("arst_teststart", int'(TestStart), 0);
    check("arst_scandata", int'(ScanData), 0);
    @(negedge Clk);
    ScanStart = 1'b0;
    @(negedge Clk);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    run_scan("post_reset", 200, 203, 1, 2, 4, -1, 0);

    // Randomized scans against the reference
    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 1023));
      else e = s + int'($urandom_range(0, 300));
      if (e > 1023) e = 1023;
      st = int'($urandom_range(30, 150));
      n = int'($urandom_range(1, 4));
      run_scan($sformatf("rnd%0d", r), s, e, st, n, -1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trig_effi_scan_ctrl.md
# trig_effi_scan_ctrl

Scan scheduler for the trigger-efficiency test block. It steps a discriminator threshold DAC code from a start value to an end value. At each point it:
- requests a slow-control reload and waits for the analog front end to settle;
- runs one trigger-efficiency measurement and forwards its 16-bit data words to the readout FIFO path, tagged with the DAC code;
- releases the test block.

It sits between the USB command decoder (scan parameters, start/stop), the slow-control loader, the trigger-efficiency test block and the readout FIFO mux.

## Interface
- DAC_WIDTH, 10: threshold DAC code width (max 15).
- SETTLE_CYCLES, 4000: Clk cycles to wait after ScLoadDone before starting a measurement (≥1).

- Clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ScanStart  in  1  level; rising edge in IDLE starts a scan.
- ScanStop  in  1  single-cycle abort request.
- DacStart, DacEnd, DacStep  in  DAC_WIDTH each  scan range and step; sampled on scan start.
- DacCode  out  DAC_WIDTH  current threshold code driven to slow control.
- ScLoadReq  out  1  one-cycle pulse requesting an SC reload with DacCode.
- ScLoadDone  in  1  one-cycle pulse when the SC reload has completed.
- TestStart  out  1  level Start to the test block.
- TestReset_n  out  1  active-low reset to the test block.
- TestDone  in  1  level; test block has finished and emitted its data.
- TestDataTransmitDone  out  1  one-cycle release pulse to the test block.
- TestData  in  16  test block data word.
- TestData_en  in  1  TestData valid.
- ScanData  out  16  word to the readout FIFO.
- ScanData_en  out  1  ScanData valid, one cycle per word.
- FifoFull  in  1  readout FIFO full.
- ScanBusy  out  1  high outside IDLE.
- ScanDone  out  1  high in DONE until ScanStart is low.
- Overflow  out  1  sticky; cleared on scan start.

## Operation
- Reset values:
  - DacCode = 0; TestReset_n = 0.
  - ScanData = 0, Overflow = 0.
  - All other outputs 0.
  - State IDLE.
- IDLE: TestReset_n = 0. When a ScanStart rising edge is detected:
  - latch range registers; a step of 0 is latched as 1;
  - set DacCode = DacStart and clear Overflow;
  - go to LOAD_SC.
- LOAD_SC: pulse ScLoadReq for 1 cycle; set TestReset_n = 1; go to WAIT_SC.
- WAIT_SC: wait for ScLoadDone; then load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: decrement the counter; at 0 go to TAG.
- TAG: emit the point tag {4'hD, 2'b00, DacCode zero-extended to 10 bits}; go to RUN.
- RUN: TestStart = 1; go to WAIT_DONE.
- WAIT_DONE:
  - while waiting, forward each TestData/TestData_en word to ScanData/ScanData_en with 1 cycle of latency;
  - when TestDone is seen, drop TestStart and go to ACK.
- ACK: pulse TestDataTransmitDone for 1 cycle; go to NEXT.
  - TestStart is already low at this point, so the test block returns to its idle state rather than restarting.
- NEXT: compute sum = DacCode + step at DAC_WIDTH+1 bits.
  - If sum > DacEnd or sum[DAC_WIDTH] = 1, go to TRAILER.
  - Otherwise DacCode = sum[DAC_WIDTH-1:0] and go to LOAD_SC.
- TRAILER: emit 16'hE0E0; go to DONE.
- DONE: ScanDone = 1. When ScanStart is low, go to IDLE.
- Boundary cases:
  - DacStart > DacEnd: exactly one point at DacStart, then the trailer.
  - DacStart = DacEnd: exactly one point.
  - DacEnd = max code, step 1: the last point is the max code; the carry bit terminates the scan without wrapping to 0.
- FifoFull while a word is emitted: the word is dropped and Overflow is set. The scan is not stalled.
- ScanStop in any state except IDLE/DONE:
  - TestStart = 0; TestReset_n = 0 for one cycle;
  - abort the current point, emit no trailer;
  - go to DONE.
- ScanStop in IDLE or DONE is ignored.
- ScanStop has priority over every other event in the same cycle, including TestDone.
- A test data word and a tag/trailer word never coincide: a tag is only emitted before TestStart rises, and the trailer only after ACK.

## Timing
- ScanStart edge → LOAD_SC: 1 cycle. ScLoadReq is asserted on the next cycle.
- ScLoadDone → TAG: SETTLE_CYCLES+1 cycles.
- TAG word → TestStart high: 1 cycle.
- TestData_en → ScanData_en: 1 cycle.
- TestDone seen → TestStart low on the next edge; TestDataTransmitDone on the following cycle.
- ACK → ScLoadReq of the next point: 2 cycles.

## Configuration
- SCAN_TAG_EN defined: point tags and the final trailer are emitted as described.
- SCAN_TAG_EN undefined:
  - TAG and TRAILER are bypassed: SETTLE goes directly to RUN, and NEXT goes directly to DONE;
  - ScanData carries test block words only.

## Test plan
- Range 100..102, step 1, SETTLE_CYCLES=4, test model returns 6 words per point → tags 0xD064, 0xD065, 0xD066, each followed by its 6 words, then 0xE0E0. Totals: 3 ScLoadReq pulses, 3 TestDataTransmitDone pulses, 22 FIFO words.
- DacStart=10, DacEnd=5 → one point at code 10, then the trailer; ScanDone = 1.
- DacEnd=1023, DacStart=1022, step=0 → points at 1022 and 1023 only; no wrap to 0.
- ScanStop asserted in WAIT_DONE together with TestDone → TestReset_n low for 1 cycle, no ACK pulse, no trailer, ScanDone = 1.
- FifoFull held during the 2nd data word → that word is missing, Overflow = 1 until the next scan start, and the scan completes normally.
- Asynchronous reset asserted mid-SETTLE → all outputs return to reset values immediately; a new ScanStart edge restarts the scan from DacStart.
